// File: rtl/alu_md_unit.sv
// alu_md_unit: EX-stage execution block for the pipelined MIPS core.
// Holds the ALU-control decode, the single-cycle ALU and an iterative
// multiply/divide sequencer that owns the HI/LO registers.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   Valid             EX instruction valid (low = bubble)
//   ALUOp, Funct      main-decoder op and R-type function field
//   Shamt             immediate shift amount
//   SrcA, SrcB        operands
//   ALUSel            decoded ALU select (combinational)
//   ALUResult, Zero   EX result and zero flag (combinational)
//   Busy              multiply/divide sequencer running
//   Stall             hold IF/ID/EX, bubble MEM this cycle
//   HI, LO            multiply/divide result registers
module alu_md_unit #(
    parameter int DWL = 32,
    parameter int AWL = 6,
    parameter int SWL = $clog2(DWL)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           Valid,
    input  logic [AWL-5:0] ALUOp,
    input  logic [AWL-1:0] Funct,
    input  logic [SWL-1:0] Shamt,
    input  logic [DWL-1:0] SrcA,
    input  logic [DWL-1:0] SrcB,
    output logic [AWL-3:0] ALUSel,
    output logic [DWL-1:0] ALUResult,
    output logic           Zero,
    output logic           Busy,
    output logic           Stall,
    output logic [DWL-1:0] HI,
    output logic [DWL-1:0] LO
);
    localparam int OW = AWL - 4;
    localparam int SW = AWL - 2;

    localparam logic [OW-1:0] OP_ADD = OW'(2'b00);
    localparam logic [OW-1:0] OP_SUB = OW'(2'b01);
    localparam logic [OW-1:0] OP_R   = OW'(2'b10);

    localparam logic [SW-1:0] S_ADD  = SW'(4'h0), S_SUB  = SW'(4'h1),
                              S_SLL  = SW'(4'h2), S_SRL  = SW'(4'h3),
                              S_SLLV = SW'(4'h4), S_SRA  = SW'(4'h5),
                              S_SRAV = SW'(4'h6), S_AND  = SW'(4'h7),
                              S_XOR  = SW'(4'h8), S_OR   = SW'(4'h9),
                              S_SLT  = SW'(4'hA), S_NOR  = SW'(4'hB),
                              S_MFHI = SW'(4'hC), S_MFLO = SW'(4'hD),
                              S_MD   = SW'(4'hE), S_BAD  = SW'(4'hF);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t         state, state_nx;
    logic [SWL-1:0] cnt, cnt_nx;
    logic [DWL-1:0] acc, acc_nx;      // product upper half / partial remainder
    logic [DWL-1:0] qreg, qreg_nx;    // multiplier -> product lower / dividend -> quotient
    logic [DWL-1:0] opb, opb_nx;      // multiplicand or divisor magnitude
    logic           sgn_q, sgn_q_nx;  // product/quotient sign
    logic           sgn_r, sgn_r_nx;  // remainder sign
    logic           is_div, is_div_nx;
    logic [DWL-1:0] hi, hi_nx, lo, lo_nx;

    logic [AWL-3:0] sel;
    logic [DWL-1:0] res;

    // ---------------- decode ----------------
    always_comb begin
        sel = S_BAD;
        case (ALUOp)
            OP_ADD: sel = S_ADD;
            OP_SUB: sel = S_SUB;
            OP_R: begin
                case (Funct)
                    AWL'(6'b100000): sel = S_ADD;
                    AWL'(6'b100010): sel = S_SUB;
                    AWL'(6'b100100): sel = S_AND;
                    AWL'(6'b100101): sel = S_OR;
                    AWL'(6'b100110): sel = S_XOR;
                    AWL'(6'b100111): sel = S_NOR;
                    AWL'(6'b101010): sel = S_SLT;
                    AWL'(6'b000000): sel = S_SLL;
                    AWL'(6'b000010): sel = S_SRL;
                    AWL'(6'b000011): sel = S_SRA;
                    AWL'(6'b000100): sel = S_SLLV;
                    AWL'(6'b000111): sel = S_SRAV;
                    AWL'(6'b010000): sel = S_MFHI;
                    AWL'(6'b010010): sel = S_MFLO;
                    AWL'(6'b011000), AWL'(6'b011001),
                    AWL'(6'b011010), AWL'(6'b011011): sel = S_MD;
                    default:         sel = S_BAD;
                endcase
            end
            default: sel = S_BAD;
        endcase
    end

    // ---------------- single-cycle ALU ----------------
    always_comb begin
        res = '0;
        case (sel)
            S_ADD:  res = SrcA + SrcB;
            S_SUB:  res = SrcA - SrcB;
            S_AND:  res = SrcA & SrcB;
            S_OR:   res = SrcA | SrcB;
            S_XOR:  res = SrcA ^ SrcB;
            S_NOR:  res = ~(SrcA | SrcB);
            S_SLT:  res = {{(DWL-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            S_SLL:  res = SrcB << Shamt;
            S_SRL:  res = SrcB >> Shamt;
            S_SRA:  res = $signed(SrcB) >>> Shamt;
            S_SLLV: res = SrcB << SrcA[SWL-1:0];
            S_SRAV: res = $signed(SrcB) >>> SrcA[SWL-1:0];
            S_MFHI: res = hi;
            S_MFLO: res = lo;
            default: res = '0;
        endcase
    end

    assign ALUSel    = sel;
    assign ALUResult = res;
    assign Zero      = (res == '0);

    // ---------------- multiply/divide sequencer ----------------
    logic busy, md_op, accept;
    assign busy   = (state != IDLE);
    assign md_op  = Valid && (sel == S_MD);
    assign Stall  = busy && Valid && (md_op || sel == S_MFHI || sel == S_MFLO);
    assign accept = md_op && (state == IDLE) && !Stall;

    // Funct[1] selects divide, Funct[0] selects unsigned.
    logic           sa, sb;
    logic [DWL-1:0] mag_a, mag_b;
    assign sa    = ~Funct[0] & SrcA[DWL-1];
    assign sb    = ~Funct[0] & SrcB[DWL-1];
    assign mag_a = sa ? -SrcA : SrcA;
    assign mag_b = sb ? -SrcB : SrcB;

    // One shift-add step: add multiplicand on LSB, shift {carry,acc,qreg} right.
    logic [DWL:0]   sum;
    assign sum = {1'b0, acc} + (qreg[0] ? {1'b0, opb} : '0);

    // One restoring step: shift in next dividend bit, keep difference if non-negative.
    logic [DWL:0]   r_sh, diff;
    assign r_sh = {acc, qreg[DWL-1]};
    assign diff = r_sh - {1'b0, opb};

    logic [2*DWL-1:0] prod, prod_fix;
    assign prod     = {acc, qreg};
    assign prod_fix = sgn_q ? -prod : prod;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        acc_nx    = acc;
        qreg_nx   = qreg;
        opb_nx    = opb;
        sgn_q_nx  = sgn_q;
        sgn_r_nx  = sgn_r;
        is_div_nx = is_div;
        hi_nx     = hi;
        lo_nx     = lo;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (Funct[1] && SrcB == '0) begin
                        lo_nx = '1;
                        hi_nx = SrcA;
                    end else begin
                        acc_nx    = '0;
                        qreg_nx   = mag_a;
                        opb_nx    = mag_b;
                        sgn_q_nx  = sa ^ sb;
                        sgn_r_nx  = sa;
                        is_div_nx = Funct[1];
                        cnt_nx    = SWL'(DWL - 1);
                        state_nx  = Funct[1] ? DIV : MUL;
                    end
                end
            end
            MUL: begin
                {acc_nx, qreg_nx} = {sum, qreg[DWL-1:1]};
                cnt_nx = cnt - 1'b1;
                if (cnt == '0) state_nx = FIX;
            end
            DIV: begin
                if (!diff[DWL]) begin
                    acc_nx  = diff[DWL-1:0];
                    qreg_nx = {qreg[DWL-2:0], 1'b1};
                end else begin
                    acc_nx  = r_sh[DWL-1:0];
                    qreg_nx = {qreg[DWL-2:0], 1'b0};
                end
                cnt_nx = cnt - 1'b1;
                if (cnt == '0) state_nx = FIX;
            end
            FIX: begin
                if (is_div) begin
                    lo_nx = sgn_q ? -qreg : qreg;
                    hi_nx = sgn_r ? -acc : acc;
                end else begin
                    {hi_nx, lo_nx} = prod_fix;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            qreg   <= '0;
            opb    <= '0;
            sgn_q  <= 1'b0;
            sgn_r  <= 1'b0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            acc    <= acc_nx;
            qreg   <= qreg_nx;
            opb    <= opb_nx;
            sgn_q  <= sgn_q_nx;
            sgn_r  <= sgn_r_nx;
            is_div <= is_div_nx;
            hi     <= hi_nx;
            lo     <= lo_nx;
        end
    end

    assign Busy = busy;
    assign HI   = hi;
    assign LO   = lo;
endmodule
